axi_refill_line_buffer: RTL and testbench
=========================================

AXI_REFILL_LINE_BUFFER -- requirements
Module: axi_refill_line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, beat and word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width in bits.
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per line; power of two, range 2..16.
REQ-005 SHALL have parameter REFILL_ID, default 0, ID value placed on arid and expected on rid.
REQ-006 SHALL have the following ports, in this order:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- req_valid  in  1  core miss request.
- req_addr  in  ADDR_WIDTH  miss byte address.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  requested word available.
- resp_data  out  DATA_WIDTH  requested word.
- resp_ready  in  1  core accepts the word.
- line_valid  out  1  one-cycle pulse: line complete.
- line_addr  out  ADDR_WIDTH  line-aligned address.
- line_data  out  DATA_WIDTH*LINE_WORDS  full line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ren  out  1  read request to the burst read master.
- arid  out  ID_WIDTH  request ID.
- arsize  out  3  transfer size.
- arlen  out  4  burst length.
- araddr  out  ADDR_WIDTH  burst start address.
- raddr_ok  in  1  master is idle; a request is accepted when ren and raddr_ok are both high.
- rdata_ok  in  1  one beat is valid this cycle.
- sram_rdata  in  DATA_WIDTH  beat data.
- rid  in  ID_WIDTH  beat ID.
- data_resp  out  1  high in FILL.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, FILL and DONE, one-hot encoded; the reset state SHALL be IDLE.
REQ-008 IDLE: when req_valid && req_ready, the block SHALL latch line_addr = req_addr with its low log2(LINE_WORDS*DATA_WIDTH/8) bits cleared, latch crit = the word index from req_addr, and move to ISSUE.
REQ-009 ISSUE: the block SHALL hold ren=1, araddr=line_addr, arlen=LINE_WORDS-1, arsize=3'b010 and arid=REFILL_ID.
REQ-010 In ISSUE, when ren && raddr_ok, the block SHALL move to FILL on the next cycle; ren SHALL be 0 in all other states.
REQ-011 FILL: on each rdata_ok with rid==REFILL_ID, the block SHALL write sram_rdata into word beat_cnt and increment beat_cnt, which is 4 bits and cleared on entry to FILL.
REQ-012 In FILL, rdata_ok with rid!=REFILL_ID SHALL be ignored: no write and no count.
REQ-013 When the accepted beat has beat_cnt==LINE_WORDS-1, the block SHALL move to DONE.
REQ-014 DONE SHALL last exactly one cycle with line_valid=1, then return to IDLE, or hold per REQ-016.
REQ-015 resp_data SHALL equal word crit of the line buffer, and resp_valid SHALL be asserted in DONE if the word has not yet been returned.
REQ-016 While resp_valid && !resp_ready in DONE, the block SHALL stay in DONE; line_valid SHALL pulse only on the first DONE cycle.
REQ-017 A resp handshake SHALL set the resp_done flag, which is cleared on the IDLE to ISSUE transition; resp_valid SHALL never be asserted while resp_done=1.
REQ-018 req_valid outside IDLE SHALL be ignored, with req_ready=0.
REQ-019 rdata_ok outside FILL SHALL be ignored.
REQ-020 An unaccepted ren in ISSUE SHALL hold araddr, arlen, arsize and arid stable.
REQ-021 Latency, without early restart: the last beat on cycle T SHALL give line_valid and resp_valid on T+1.

Reset
REQ-022 On ARESETn=0 at a clock edge, at any state including mid-FILL, the block SHALL enter IDLE.
REQ-023 On that reset, every output SHALL be driven to 0 except req_ready, which SHALL be 1 the cycle after reset deasserts.
REQ-024 On that reset, beat_cnt, crit and resp_done SHALL be cleared and line_data SHALL be zeroed; the partially filled line SHALL be discarded.

Configuration
REQ-025 Macro REFILL_EARLY_RESTART_EN SHALL select when the requested word is returned.
REQ-026 With REFILL_EARLY_RESTART_EN defined, resp_valid SHALL also be asserted in FILL, from the cycle after the beat with index crit is written, until the handshake; a resp handshake in FILL SHALL set resp_done.
REQ-027 With REFILL_EARLY_RESTART_EN defined, FILL SHALL continue to the last beat regardless of resp_ready, and the last-beat transition to DONE SHALL proceed even while resp_valid is pending.
REQ-028 Without REFILL_EARLY_RESTART_EN, resp_valid SHALL be asserted only in DONE.

Verification
REQ-029 The bench SHALL cover: req_addr=0x1008, raddr_ok=1, four beats 0xA0..0xA3 with rid=0 -> araddr=0x1000, arlen=3, arid=0; line_data={A3,A2,A1,A0}; resp_data=0xA2; line_valid one cycle after beat 3.
REQ-030 The bench SHALL cover: raddr_ok=0 for 5 cycles in ISSUE -> ren held 1 with stable araddr and arlen; request accepted on the 6th cycle.
REQ-031 The bench SHALL cover: a beat with rid=5 interleaved mid-FILL -> ignored; beat_cnt unchanged; line correct.
REQ-032 The bench SHALL cover: ARESETn low after 2 beats, then a new miss to 0x2000 -> no line_valid for the aborted line; new araddr=0x2000; beat_cnt restarts at 0.
REQ-033 The bench SHALL cover: resp_ready low for 3 cycles in DONE -> stays in DONE; line_valid pulses once; req_ready=0 until the handshake.
REQ-034 The bench SHALL cover, with REFILL_EARLY_RESTART_EN defined: req_addr=0x1000 -> resp_valid the cycle after beat 0; handshake in FILL; no resp_valid in DONE.

Source files
------------

// File: rtl/axi_refill_line_buffer.sv
// rtl/axi_refill_line_buffer.sv - cache-line refill over an AXI-style burst read; macro REFILL_EARLY_RESTART_EN returns the critical word during FILL
module axi_refill_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LINE_WORDS = 4,
  parameter int REFILL_ID  = 0
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic                             req_valid,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  input  logic                             resp_ready,
  output logic                             line_valid,
  output logic [ADDR_WIDTH-1:0]            line_addr,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] line_data,
  output logic                             ren,
  output logic [ID_WIDTH-1:0]              arid,
  output logic [2:0]                       arsize,
  output logic [3:0]                       arlen,
  output logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             raddr_ok,
  input  logic                             rdata_ok,
  input  logic [DATA_WIDTH-1:0]            sram_rdata,
  input  logic [ID_WIDTH-1:0]              rid,
  output logic                             data_resp
);

  // Byte-in-word bits, word-in-line bits and total line offset bits.
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int IDX_BITS  = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = BYTE_BITS + IDX_BITS;
  localparam int LINE_BITS = DATA_WIDTH * LINE_WORDS;

  localparam logic [3:0]          LAST_BEAT   = 4'(LINE_WORDS - 1);
  localparam logic [ID_WIDTH-1:0] REFILL_ID_V = ID_WIDTH'(REFILL_ID);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    FILL  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic [IDX_BITS-1:0]     crit_q, crit_d;
  logic [3:0]              beat_cnt_q, beat_cnt_d;
  logic                    resp_done_q, resp_done_d;
  logic                    line_sent_q, line_sent_d;
  logic [LINE_BITS-1:0]    line_q, line_d;
`ifdef REFILL_EARLY_RESTART_EN
  logic                    crit_seen_q, crit_seen_d;
`endif

  logic                    beat_hit;
  logic                    resp_hs;
  logic [DATA_WIDTH-1:0]   resp_word;
  logic                    unused_low;

  // Offset bits of the miss address only feed crit; the rest are intentionally dropped.
  assign unused_low = ^req_addr[OFF_BITS-1:0];

  // Only beats carrying our refill ID count; stray IDs are dropped.
  assign beat_hit = rdata_ok && (rid == REFILL_ID_V);

  // Critical word selected out of the line buffer.
  always_comb begin
    resp_word = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (crit_q == IDX_BITS'(i)) begin
        resp_word = line_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Critical-word return: only in DONE by default, also in FILL once written with early restart.
  always_comb begin
`ifdef REFILL_EARLY_RESTART_EN
    resp_valid = !resp_done_q &&
                 ((state_q == DONE) || ((state_q == FILL) && crit_seen_q));
`else
    resp_valid = !resp_done_q && (state_q == DONE);
`endif
  end

  assign resp_hs = resp_valid && resp_ready;

  // Next-state and datapath updates for the refill sequence.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    crit_d      = crit_q;
    beat_cnt_d  = beat_cnt_q;
    resp_done_d = resp_done_q;
    line_d      = line_q;
    line_sent_d = (state_q == DONE);
`ifdef REFILL_EARLY_RESTART_EN
    crit_seen_d = crit_seen_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = ISSUE;
          line_addr_d = {req_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
          crit_d      = req_addr[BYTE_BITS +: IDX_BITS];
          resp_done_d = 1'b0;
`ifdef REFILL_EARLY_RESTART_EN
          crit_seen_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (raddr_ok) begin
          state_d    = FILL;
          beat_cnt_d = 4'd0;
        end
      end
      FILL: begin
        if (beat_hit) begin
          for (int i = 0; i < LINE_WORDS; i++) begin
            if (beat_cnt_q == 4'(i)) begin
              line_d[i*DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
            end
          end
          beat_cnt_d = beat_cnt_q + 4'd1;
`ifdef REFILL_EARLY_RESTART_EN
          if (beat_cnt_q == 4'(crit_q)) begin
            crit_seen_d = 1'b1;
          end
`endif
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Hold until the critical word is taken; leave at once if it already was.
        if (!(resp_valid && !resp_ready)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_hs) begin
      resp_done_d = 1'b1;
    end
  end

  // State and datapath registers; reset discards any partially filled line.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      crit_q      <= '0;
      beat_cnt_q  <= '0;
      resp_done_q <= 1'b0;
      line_sent_q <= 1'b0;
      line_q      <= '0;
`ifdef REFILL_EARLY_RESTART_EN
      crit_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      crit_q      <= crit_d;
      beat_cnt_q  <= beat_cnt_d;
      resp_done_q <= resp_done_d;
      line_sent_q <= line_sent_d;
      line_q      <= line_d;
`ifdef REFILL_EARLY_RESTART_EN
      crit_seen_q <= crit_seen_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign ren        = (state_q == ISSUE);
  assign arid       = ren ? REFILL_ID_V : '0;
  assign arsize     = ren ? 3'b010 : 3'b000;
  assign arlen      = ren ? LAST_BEAT : 4'd0;
  assign araddr     = ren ? line_addr_q : '0;
  assign data_resp  = (state_q == FILL);
  assign line_valid = (state_q == DONE) && !line_sent_q;
  assign line_addr  = line_addr_q;
  assign line_data  = line_q;
  assign resp_data  = resp_word;

endmodule

// File: tb/tb_axi_refill_line_buffer.sv
// tb/tb_axi_refill_line_buffer.sv - directed bench with cycle compare against a behavioural refill model
module tb_axi_refill_line_buffer;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int LW  = 4;
  localparam int RID = 0;
  localparam int LB  = DW * LW;
`ifdef REFILL_EARLY_RESTART_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_ready = 1'b0;
  logic          line_valid;
  logic [AW-1:0] line_addr;
  logic [LB-1:0] line_data;
  logic          ren;
  logic [IW-1:0] arid;
  logic [2:0]    arsize;
  logic [3:0]    arlen;
  logic [AW-1:0] araddr;
  logic          raddr_ok = 1'b0;
  logic          rdata_ok = 1'b0;
  logic [DW-1:0] sram_rdata = '0;
  logic [IW-1:0] rid = '0;
  logic          data_resp;

  always #5 ACLK = ~ACLK;

  axi_refill_line_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_WORDS(LW), .REFILL_ID(RID)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data),
    .ren(ren), .arid(arid), .arsize(arsize), .arlen(arlen), .araddr(araddr),
    .raddr_ok(raddr_ok), .rdata_ok(rdata_ok), .sram_rdata(sram_rdata), .rid(rid),
    .data_resp(data_resp)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int lv_pulses = 0;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 address, 2 data, 3 line complete.
  int            m_phase = 0;
  logic [AW-1:0] m_laddr = '0;
  int            m_crit = 0;
  logic [DW-1:0] m_line [LW];
  int            m_nbeats = 0;
  bit            m_returned = 1'b0;
  int            m_done_cyc = 0;

  function automatic bit exp_resp_valid();
    return !m_returned &&
           (m_phase == 3 || (EARLY == 1 && m_phase == 2 && m_nbeats > m_crit));
  endfunction

  function automatic logic [LB-1:0] exp_line();
    logic [LB-1:0] v;
    v = '0;
    for (int i = 0; i < LW; i++) v[i*DW +: DW] = m_line[i];
    return v;
  endfunction

  always @(posedge ACLK) begin
    bit rv;
    rv = exp_resp_valid();
    if (!ARESETn) begin
      m_phase = 0; m_laddr = '0; m_crit = 0; m_nbeats = 0;
      m_returned = 1'b0; m_done_cyc = 0;
      for (int i = 0; i < LW; i++) m_line[i] = '0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
             m_laddr    = req_addr - (req_addr % (LW * DW / 8));
             m_crit     = int'((req_addr % (LW * DW / 8)) / (DW / 8));
             m_returned = 1'b0;
             m_phase    = 1;
           end
        1: if (raddr_ok) begin
             m_phase  = 2;
             m_nbeats = 0;
           end
        2: begin
             if (rv && resp_ready) m_returned = 1'b1;
             if (rdata_ok && rid == RID) begin
               m_line[m_nbeats] = sram_rdata;
               m_nbeats++;
               if (m_nbeats == LW) begin
                 m_phase = 3;
                 m_done_cyc = 0;
               end
             end
           end
        default: begin
             if (rv && !resp_ready) m_done_cyc++;
             else begin
               if (rv) m_returned = 1'b1;
               m_phase = 0;
             end
           end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge ACLK) begin
    if (cmp_en) begin
      if (line_valid === 1'b1) lv_pulses++;
      chk("req_ready", req_ready, m_phase == 0);
      chk("ren", ren, m_phase == 1);
      chk("araddr", araddr, m_phase == 1 ? m_laddr : 0);
      chk("arlen", arlen, m_phase == 1 ? LW - 1 : 0);
      chk("arsize", arsize, m_phase == 1 ? 2 : 0);
      chk("arid", arid, m_phase == 1 ? RID : 0);
      chk("data_resp", data_resp, m_phase == 2);
      chk("line_valid", line_valid, m_phase == 3 && m_done_cyc == 0);
      chk("resp_valid", resp_valid, exp_resp_valid());
      chk("resp_data", resp_data, m_line[m_crit]);
      chk("line_addr", line_addr, m_laddr);
      chk("line_data", line_data, exp_line());
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic miss(input logic [AW-1:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic accept();
    raddr_ok = 1'b1;
    tick();
    raddr_ok = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [IW-1:0] id);
    rdata_ok = 1'b1; sram_rdata = d; rid = id;
    tick();
    rdata_ok = 1'b0; rid = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    tick();
    tick();
    cmp_en = 1'b1;
    ARESETn = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ren", ren, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_araddr", araddr, 0);

    // Basic refill, critical word 2.
    miss(32'h1008);
    chk("s1_ren", ren, 1);
    chk("s1_araddr", araddr, 32'h1000);
    chk("s1_arlen", arlen, 3);
    chk("s1_arid", arid, 0);
    chk("s1_arsize", arsize, 3'b010);
    chk("s1_model_crit", m_crit, 2);
    accept();
    beat(32'hA0, 4'd0);
    beat(32'hA1, 4'd0);
    beat(32'hA2, 4'd0);
    chk("s1_no_early_line_valid", line_valid, 0);
    beat(32'hA3, 4'd0);
    chk("s1_line_valid", line_valid, 1);
    chk("s1_resp_valid", resp_valid, 1);
    chk("s1_resp_data", resp_data, 32'hA2);
    chk("s1_line_data", line_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("s1_line_addr", line_addr, 32'h1000);
    resp_ready = 1'b1;
    tick();
    chk("s1_back_idle", req_ready, 1);
    resp_ready = 1'b0;

    // Address stall for 5 cycles with stray req/rdata that must be ignored.
    miss(32'h3004);
    req_valid = 1'b1; req_addr = 32'h7777_0000;
    rdata_ok = 1'b1; sram_rdata = 32'hBAD; rid = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("s2_ren_held", ren, 1);
      chk("s2_araddr_held", araddr, 32'h3000);
      chk("s2_arlen_held", arlen, 3);
      tick();
    end
    req_valid = 1'b0; rdata_ok = 1'b0;
    chk("s2_ren_6th", ren, 1);
    accept();
    chk("s2_fill", data_resp, 1);
    resp_ready = 1'b1;
    beat(32'hB0, 4'd0);
    beat(32'hB1, 4'd0);
    beat(32'hB2, 4'd0);
    beat(32'hB3, 4'd0);
    chk("s2_line_data", line_data, 128'h000000B3_000000B2_000000B1_000000B0);
    wait_idle("s2_idle");
    resp_ready = 1'b0;

    // Foreign-ID beat mid-fill is dropped.
    miss(32'h400C);
    accept();
    beat(32'hC0, 4'd0);
    beat(32'hEE, 4'd5);
    beat(32'hC1, 4'd0);
    beat(32'hC2, 4'd0);
    chk("s3_still_fill", data_resp, 1);
    beat(32'hC3, 4'd0);
    chk("s3_line_valid", line_valid, 1);
    chk("s3_line_data", line_data, 128'h000000C3_000000C2_000000C1_000000C0);
    chk("s3_resp_data", resp_data, 32'hC3);
    resp_ready = 1'b1;
    tick();
    wait_idle("s3_idle");
    resp_ready = 1'b0;

    // Reset mid-fill, then a fresh miss.
    p = lv_pulses;
    miss(32'h5000);
    accept();
    beat(32'hD0, 4'd0);
    beat(32'hD1, 4'd0);
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    chk("s4_req_ready", req_ready, 1);
    chk("s4_line_data_zero", line_data, 0);
    chk("s4_data_resp", data_resp, 0);
    chk("s4_no_line_valid", lv_pulses - p, 0);
    miss(32'h2000);
    chk("s4_araddr", araddr, 32'h2000);
    accept();
    beat(32'hE0, 4'd0);
    beat(32'hE1, 4'd0);
    beat(32'hE2, 4'd0);
    beat(32'hE3, 4'd0);
    chk("s4_line_valid", line_valid, 1);
    chk("s4_line_data", line_data, 128'h000000E3_000000E2_000000E1_000000E0);
    chk("s4_no_line_valid_aborted", lv_pulses - p, 0);
    resp_ready = 1'b1;
    tick();
    wait_idle("s4_idle");
    resp_ready = 1'b0;

    // Core back-pressure in DONE for 3 cycles.
    p = lv_pulses;
    miss(32'h6008);
    accept();
    beat(32'h60, 4'd0);
    beat(32'h61, 4'd0);
    beat(32'h62, 4'd0);
    beat(32'h63, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("s5_resp_valid", resp_valid, 1);
      chk("s5_req_ready", req_ready, 0);
      chk("s5_line_valid", line_valid, i == 0);
      tick();
    end
    resp_ready = 1'b1;
    chk("s5_resp_valid_hs", resp_valid, 1);
    chk("s5_resp_data", resp_data, 32'h62);
    tick();
    resp_ready = 1'b0;
    chk("s5_idle", req_ready, 1);
    chk("s5_one_pulse", lv_pulses - p, 1);

`ifdef REFILL_EARLY_RESTART_EN
    // Early restart: critical word 0 returned during FILL.
    miss(32'h1000);
    accept();
    chk("s6_no_resp_yet", resp_valid, 0);
    beat(32'hF0, 4'd0);
    chk("s6_early_resp_valid", resp_valid, 1);
    chk("s6_in_fill", data_resp, 1);
    chk("s6_resp_data", resp_data, 32'hF0);
    resp_ready = 1'b1;
    beat(32'hF1, 4'd0);
    resp_ready = 1'b0;
    chk("s6_resp_taken", resp_valid, 0);
    beat(32'hF2, 4'd0);
    beat(32'hF3, 4'd0);
    chk("s6_line_valid", line_valid, 1);
    chk("s6_no_resp_in_done", resp_valid, 0);
    tick();
    chk("s6_idle", req_ready, 1);
`endif

    tick();
    chk("total_lines", lv_pulses, 5 + EARLY);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
